// File: rtl/windup_clock_mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : windup_clock_mc_pkg
//  Description : Shared constants and helpers for the multi-channel wind-up
//                clock generator (default sizes, mode encodings, lane slicing).
//  Revision    : 1.0 - initial release
// ============================================================================
package windup_clock_mc_pkg;

    // Default sizing for the top level
    localparam int DEF_CH  = 4;
    localparam int DEF_BIT = 16;

    // Mode encodings, sampled together with the load strobe
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_AUTO    = 1'b1;

    // Flat buses carry channel c in bits [lane_lsb(c, w) +: w]
    function automatic int lane_lsb(input int c, input int w);
        return c * w;
    endfunction

endpackage : windup_clock_mc_pkg
`default_nettype wire

// File: rtl/clock_gate_latch.sv
`default_nettype none
// ============================================================================
//  Module      : clock_gate_latch
//  Description : Latch-plus-AND clock gate. The enable is captured while the
//                clock is low so the gated high phase is never truncated.
//                Isolated so it can be replaced by a library ICG cell.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_gate_latch (
    input  logic clk_in,
    input  logic rst_n,
    input  logic en,
    output logic clk_out
);

    logic r_en_lat;

    // Transparent-low enable latch; reset clears it so the output drops at once
    always_latch begin
        if (!rst_n) begin
            r_en_lat <= 1'b0;
        end else if (!clk_in) begin
            r_en_lat <= en;
        end
    end

    assign clk_out = clk_in & r_en_lat;

endmodule : clock_gate_latch
`default_nettype wire

// File: rtl/windup_channel.sv
`default_nettype none
// ============================================================================
//  Module      : windup_channel
//  Description : One wind-up counter lane: count, reload value, auto-reload
//                flag and registered done pulse, with stop > load > countdown
//                priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module windup_channel
    import windup_clock_mc_pkg::*;
#(
    parameter int BIT = DEF_BIT
) (
    input  logic           clk_in,
    input  logic           rst_n,
    input  logic           wr_en,
    input  logic [BIT-1:0] wind,
    input  logic           mode,
    input  logic           hold,
    input  logic           stop,
    output logic           en_out,
    output logic           done,
    output logic           busy,
    output logic [BIT-1:0] count_out
);

    localparam logic [BIT-1:0] C_ZERO = '0;
    localparam logic [BIT-1:0] C_ONE  = BIT'(1);

    logic [BIT-1:0] r_count;
    logic [BIT-1:0] r_reload;
    logic           r_auto;
    logic           r_done;
    logic           w_busy;
    logic           w_en;

    // Enable is suppressed in any cycle where a load or abort takes precedence
    assign w_busy = (r_count != C_ZERO);
    assign w_en   = w_busy & ~hold & ~wr_en & ~stop;

    // Counter, reload register, mode flag and done pulse
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= C_ZERO;
            r_reload <= C_ZERO;
            r_auto   <= MODE_ONESHOT;
            r_done   <= 1'b0;
        end else if (stop) begin
            r_count  <= C_ZERO;
            r_reload <= C_ZERO;
            r_auto   <= MODE_ONESHOT;
            r_done   <= 1'b0;
        end else if (wr_en) begin
            r_count  <= wind;
            r_reload <= wind;
            r_auto   <= mode;
            r_done   <= 1'b0;
        end else if (w_en) begin
            if (r_count == C_ONE) begin
                // Reload is non-zero whenever a period is running in auto mode
                r_count <= (r_auto == MODE_AUTO) ? r_reload : C_ZERO;
                r_done  <= 1'b1;
            end else begin
                r_count <= r_count - C_ONE;
                r_done  <= 1'b0;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign en_out    = w_en;
    assign done      = r_done;
    assign busy      = w_busy;
    assign count_out = r_count;

endmodule : windup_channel
`default_nettype wire

// File: rtl/windup_clock_mc.sv
`default_nettype none
// ============================================================================
//  Module      : windup_clock_mc
//  Description : Multi-channel wind-up clock generator. Each channel runs for
//                a loaded number of enabled cycles (one-shot or periodic) and
//                provides an enable, a glitch-free gated clock and done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module windup_clock_mc
    import windup_clock_mc_pkg::*;
#(
    parameter int CH  = DEF_CH,
    parameter int BIT = DEF_BIT
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [CH-1:0]     wr_en,
    input  logic [CH*BIT-1:0] wind,
    input  logic [CH-1:0]     mode,
    input  logic [CH-1:0]     hold,
    input  logic [CH-1:0]     stop,
    output logic [CH-1:0]     en_out,
    output logic [CH-1:0]     clk_out,
    output logic [CH-1:0]     done,
    output logic [CH-1:0]     busy,
    output logic [CH*BIT-1:0] count_out
);

    // One counter lane plus one clock gate per channel
    for (genvar c = 0; c < CH; c++) begin : g_ch
        localparam int LSB = lane_lsb(c, BIT);

        windup_channel #(
            .BIT (BIT)
        ) u_channel (
            .clk_in    (clk_in),
            .rst_n     (rst_n),
            .wr_en     (wr_en[c]),
            .wind      (wind[LSB +: BIT]),
            .mode      (mode[c]),
            .hold      (hold[c]),
            .stop      (stop[c]),
            .en_out    (en_out[c]),
            .done      (done[c]),
            .busy      (busy[c]),
            .count_out (count_out[LSB +: BIT])
        );

        clock_gate_latch u_gate (
            .clk_in  (clk_in),
            .rst_n   (rst_n),
            .en      (en_out[c]),
            .clk_out (clk_out[c])
        );
    end

endmodule : windup_clock_mc
`default_nettype wire

// File: tb/tb_windup_clock_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_windup_clock_mc
//  Description : Self-checking bench for windup_clock_mc (CH=4, BIT=4):
//                table-driven per-cycle vectors plus hand-written sequences
//                for auto-reload, maximum wind and asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_windup_clock_mc;

    localparam int CH  = 4;
    localparam int BIT = 4;

    logic              clk_in;
    logic              rst_n;
    logic [CH-1:0]     wr_en;
    logic [CH*BIT-1:0] wind;
    logic [CH-1:0]     mode;
    logic [CH-1:0]     hold;
    logic [CH-1:0]     stop;
    logic [CH-1:0]     en_out;
    logic [CH-1:0]     clk_out;
    logic [CH-1:0]     done;
    logic [CH-1:0]     busy;
    logic [CH*BIT-1:0] count_out;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses [CH];

    windup_clock_mc #(
        .CH  (CH),
        .BIT (BIT)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wind      (wind),
        .mode      (mode),
        .hold      (hold),
        .stop      (stop),
        .en_out    (en_out),
        .clk_out   (clk_out),
        .done      (done),
        .busy      (busy),
        .count_out (count_out)
    );

    // 10-unit clock: rising edges at 5, 15, ...; inputs change on falling edges
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Count gated-clock pulses per channel, sampled inside the high phase
    initial begin
        for (int c = 0; c < CH; c++) pulses[c] = 0;
        forever begin
            @(posedge clk_in);
            #2;
            for (int c = 0; c < CH; c++) if (clk_out[c]) pulses[c]++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        wr_en = '0;
        wind  = '0;
        mode  = '0;
        hold  = '0;
        stop  = '0;
    endtask

    typedef struct {
        int         ch;
        logic       wr;
        logic [3:0] wv;
        logic       md;
        logic       hl;
        logic       st;
        logic       en;
        logic       dn;
        logic       bz;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [CH-1:0] e_en, e_dn, e_bz;
        logic [CH*BIT-1:0] e_cnt;
        int snap [CH];
        int en_n, dn_n, dn_at;

        // Fields: ch, wr, wind, mode, hold, stop | en, done, busy, count
        // One-shot ch1, wind=3
        vecs.push_back('{1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
        vecs.push_back('{1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3});
        vecs.push_back('{1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2});
        vecs.push_back('{1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1});
        vecs.push_back('{1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0});
        vecs.push_back('{1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
        // Hold on ch0, wind=4, two hold cycles after the 2nd enabled cycle
        vecs.push_back('{0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
        vecs.push_back('{0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd4});
        vecs.push_back('{0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3});
        vecs.push_back('{0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2});
        vecs.push_back('{0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2});
        vecs.push_back('{0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2});
        vecs.push_back('{0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1});
        vecs.push_back('{0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0});
        vecs.push_back('{0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
        // Priority on ch3: count=1 with load+stop -> stop wins
        vecs.push_back('{3, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
        vecs.push_back('{3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2});
        vecs.push_back('{3, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1});
        vecs.push_back('{3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
        // Priority on ch3: count=1 with load only -> reload to 5, no done
        vecs.push_back('{3, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
        vecs.push_back('{3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2});
        vecs.push_back('{3, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1});
        vecs.push_back('{3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5});
        vecs.push_back('{3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4});
        vecs.push_back('{3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
        // Zero wind on ch2
        vecs.push_back('{2, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
        vecs.push_back('{2, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
        vecs.push_back('{2, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});

        // Reset state
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk_in);
        #3;
        chk("reset en_out", 32'(en_out), 32'h0);
        chk("reset done", 32'(done), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset count_out", 32'(count_out), 32'h0);
        chk("reset clk_out", 32'(clk_out), 32'h0);
        @(negedge clk_in);
        rst_n = 1'b1;

        // Table-driven per-cycle vectors
        for (int c = 0; c < CH; c++) snap[c] = pulses[c];
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_in);
            clear_inputs();
            wr_en[vecs[i].ch] = vecs[i].wr;
            wind[vecs[i].ch*BIT +: BIT] = vecs[i].wv;
            mode[vecs[i].ch]  = vecs[i].md;
            hold[vecs[i].ch]  = vecs[i].hl;
            stop[vecs[i].ch]  = vecs[i].st;
            e_en = '0;  e_en[vecs[i].ch] = vecs[i].en;
            e_dn = '0;  e_dn[vecs[i].ch] = vecs[i].dn;
            e_bz = '0;  e_bz[vecs[i].ch] = vecs[i].bz;
            e_cnt = '0; e_cnt[vecs[i].ch*BIT +: BIT] = vecs[i].cnt;
            #3;
            chk($sformatf("vec%0d en_out", i), 32'(en_out), 32'(e_en));
            chk($sformatf("vec%0d done", i), 32'(done), 32'(e_dn));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(e_bz));
            chk($sformatf("vec%0d count_out", i), 32'(count_out), 32'(e_cnt));
        end
        @(negedge clk_in);
        clear_inputs();
        @(negedge clk_in);
        // Gated pulses equal enabled cycles: ch0 4, ch1 3, ch2 0, ch3 3
        chk("pulses ch0", 32'(pulses[0] - snap[0]), 32'd4);
        chk("pulses ch1", 32'(pulses[1] - snap[1]), 32'd3);
        chk("pulses ch2", 32'(pulses[2] - snap[2]), 32'd0);
        chk("pulses ch3", 32'(pulses[3] - snap[3]), 32'd3);

        // Auto-reload on ch2, wind=2: done in cycles 3, 5, 7 after load
        @(negedge clk_in);
        wr_en[2] = 1'b1; wind[2*BIT +: BIT] = 4'd2; mode[2] = 1'b1;
        @(negedge clk_in);
        clear_inputs();
        for (int i = 1; i <= 7; i++) begin
            #3;
            chk($sformatf("auto c%0d en", i), 32'(en_out[2]), 32'd1);
            chk($sformatf("auto c%0d done", i), 32'(done[2]), ((i % 2 == 1) && i >= 3) ? 32'd1 : 32'd0);
            chk($sformatf("auto c%0d count", i), 32'(count_out[2*BIT +: BIT]), (i % 2 == 1) ? 32'd2 : 32'd1);
            @(negedge clk_in);
        end
        stop[2] = 1'b1;
        #3;
        chk("auto stop en", 32'(en_out[2]), 32'd0);
        @(negedge clk_in);
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            #3;
            chk($sformatf("auto post-stop%0d done", i), 32'(done[2]), 32'd0);
            chk($sformatf("auto post-stop%0d count", i), 32'(count_out[2*BIT +: BIT]), 32'd0);
            @(negedge clk_in);
        end

        // Maximum wind on ch0: 15 enabled cycles, one done, no underflow
        wr_en[0] = 1'b1; wind[BIT-1:0] = 4'hF;
        @(negedge clk_in);
        clear_inputs();
        en_n = 0; dn_n = 0; dn_at = -1;
        for (int i = 0; i < 20; i++) begin
            #3;
            if (en_out[0]) en_n++;
            if (done[0]) begin
                dn_n++;
                dn_at = i;
            end
            @(negedge clk_in);
        end
        chk("max en cycles", 32'(en_n), 32'd15);
        chk("max done count", 32'(dn_n), 32'd1);
        chk("max done cycle", 32'(dn_at), 32'd15);
        chk("max final count", 32'(count_out[BIT-1:0]), 32'd0);

        // Asynchronous reset mid-run on ch0 while the gated clock is high
        wr_en[0] = 1'b1; wind[BIT-1:0] = 4'd5;
        @(negedge clk_in);
        clear_inputs();
        #3;
        chk("rst pre count", 32'(count_out[BIT-1:0]), 32'd5);
        chk("rst pre en", 32'(en_out[0]), 32'd1);
        @(posedge clk_in);
        #2;
        chk("rst pre clk_out", 32'(clk_out[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst count_out", 32'(count_out), 32'h0);
        chk("rst en_out", 32'(en_out), 32'h0);
        chk("rst clk_out", 32'(clk_out), 32'h0);
        chk("rst done", 32'(done), 32'h0);
        @(negedge clk_in);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_in);
            #3;
            chk($sformatf("post-rst%0d busy", i), 32'(busy), 32'h0);
            chk($sformatf("post-rst%0d done", i), 32'(done), 32'h0);
            chk($sformatf("post-rst%0d en", i), 32'(en_out), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_windup_clock_mc
`default_nettype wire
